// File: rtl/id_issue_scoreboard_pkg.sv
// issue_pkg: unit codes, latency/pipelining tables and sizing constants for the ID issue scoreboard
package issue_pkg;
    localparam int NREGS  = 16;
    localparam int RW     = $clog2(NREGS);
    localparam int UNITW  = 4;
    localparam int CNTW   = 3;
    localparam int PERFW  = 16;
    localparam int NUNITS = 2 ** UNITW;

    typedef enum logic [UNITW-1:0] {
        UNIT_NOP = 4'd0,
        UNIT_ALU = 4'd1,
        UNIT_MUL = 4'd2,
        UNIT_DIV = 4'd3,
        UNIT_LSU = 4'd4
    } unit_e;

    // Result latency per unit code; unassigned codes behave like a single-cycle unit.
    localparam logic [CNTW-1:0] UNIT_LAT [NUNITS] = '{
        3'd0, 3'd1, 3'd3, 3'd4, 3'd2, 3'd1, 3'd1, 3'd1,
        3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1
    };

    // Only the divider blocks further issue while it is working.
    localparam logic [NUNITS-1:0] UNIT_PIPELINED = 16'b1111_1111_1111_0111;

    function automatic logic [CNTW-1:0] unit_lat(input logic [UNITW-1:0] u);
        return UNIT_LAT[u];
    endfunction
endpackage

// File: rtl/id_issue_scoreboard_reg_tracker.sv
// reg_tracker: busy bit and latency countdown for one register; SCOREBOARD_FWD_EN makes it ready at countdown zero
module reg_tracker
    import issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            set,
    input  logic            clr,
    input  logic [CNTW-1:0] lat,
    output logic            busy,
    output logic            rdy
);
    logic [CNTW-1:0] cnt;

`ifdef SCOREBOARD_FWD_EN
    assign rdy = cnt == '0;
`else
    assign rdy = !busy;
`endif

    // Flush beats issue, issue beats writeback, otherwise count down toward zero.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            busy <= 1'b1;
            cnt  <= lat;
        end else if (clr) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
        end
endmodule

// File: rtl/id_issue_scoreboard.sv
// id_issue_scoreboard: ID-side issue control with per-register scoreboard and structural hazards; option SCOREBOARD_FWD_EN
module id_issue_scoreboard
    import issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_Rd,
    input  logic [RW-1:0]    id_Rs1,
    input  logic [RW-1:0]    id_Rs2,
    input  logic [UNITW-1:0] id_unit,
    input  logic             id_wr_rd,
    input  logic             id_use_rs2,
    input  logic             ex_hold,
    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_Rd,
    input  logic             flush,
    output logic             wr_allow,
    output logic             id_stall,
    output logic             bubble,
    output logic [NREGS-1:0] busy_vec,
    output logic [PERFW-1:0] stall_cnt
);
    logic [NREGS-1:0] rdy;
    logic [CNTW-1:0]  occ [NUNITS];
    logic [CNTW-1:0]  lat;
    logic             unit_occ, haz, issue;

    assign lat      = unit_lat(id_unit);
    assign unit_occ = occ[id_unit] != '0;
    assign haz      = id_valid && (!rdy[id_Rs1] || (id_use_rs2 && !rdy[id_Rs2]) || unit_occ);
    assign issue    = id_valid && !haz && !ex_hold;
    assign wr_allow = !ex_hold;
    assign id_stall = haz || ex_hold;
    assign bubble   = haz && !ex_hold;

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_trk
            reg_tracker u_trk (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (flush),
                .set   (issue && id_wr_rd && id_Rd == RW'(g)),
                .clr   (wb_valid && wb_Rd == RW'(g)),
                .lat   (lat),
                .busy  (busy_vec[g]),
                .rdy   (rdy[g])
            );
        end
    endgenerate

    // Non-pipelined units stay occupied for their latency after each issue.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int u = 0; u < NUNITS; u++) occ[u] <= '0;
        else
            for (int u = 0; u < NUNITS; u++)
                occ[u] <= flush ? '0 :
                          (issue && !UNIT_PIPELINED[u] && id_unit == UNITW'(u)) ? lat :
                          (occ[u] != '0) ? occ[u] - 1'b1 : '0;

    // Saturating count of cycles in which ID is frozen; survives flush.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            stall_cnt <= '0;
        else if (id_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
endmodule
